// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - Pong score keeper: start sync/edge detect, serve/play/point/over FSM, score counters.
// Optional start-button debounce enabled by defining SCORE_DEBOUNCE_EN.
module score_keeper #(
  parameter int WIN_SCORE       = 7,
  parameter int LEFT_GOAL_X     = 10,
  parameter int RIGHT_GOAL_X    = 630,
  parameter int SERVE_DELAY     = 25000000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [9:0] ball_x_pos,
  output logic       serve,
  output logic       play_en,
  output logic [3:0] left_score,
  output logic [3:0] right_score,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [3:0]  WIN      = 4'(WIN_SCORE);
  localparam logic [9:0]  LEFT_X   = 10'(LEFT_GOAL_X);
  localparam logic [9:0]  RIGHT_X  = 10'(RIGHT_GOAL_X);
  localparam logic [24:0] DELAY_M1 = 25'(SERVE_DELAY - 1);

  if (WIN_SCORE < 1 || WIN_SCORE > 15) begin : g_bad_win
    $error("WIN_SCORE out of range");
  end
  if (SERVE_DELAY < 1 || SERVE_DELAY > 33554431) begin : g_bad_delay
    $error("SERVE_DELAY out of range");
  end
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 1048575) begin : g_bad_db
    $error("DEBOUNCE_CYCLES out of range");
  end

  state_t      cur, nxt;
  logic        sync1, sync2, lvl, lvl_d, start_evt;
  logic [24:0] cnt;
  logic        left_goal, right_goal, win_reached;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      lvl_d     <= 1'b0;
      start_evt <= 1'b0;
    end else begin
      sync1     <= start;
      sync2     <= sync1;
      lvl_d     <= lvl;
      start_evt <= lvl & ~lvl_d;
    end
  end

`ifdef SCORE_DEBOUNCE_EN
  localparam logic [19:0] DB_MAX = 20'(DEBOUNCE_CYCLES - 1);
  logic        db_level;
  logic [19:0] db_cnt;

  // The level only flips once the synchronized input has disagreed with it for DEBOUNCE_CYCLES straight cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_level <= 1'b0;
      db_cnt   <= 20'd0;
    end else if (sync2 == db_level) begin
      db_cnt <= 20'd0;
    end else if (db_cnt == DB_MAX) begin
      db_level <= sync2;
      db_cnt   <= 20'd0;
    end else begin
      db_cnt <= db_cnt + 20'd1;
    end
  end
  assign lvl = db_level;
`else
  assign lvl = sync2;
`endif

  assign left_goal   = (ball_x_pos <= LEFT_X);
  assign right_goal  = (ball_x_pos >= RIGHT_X);
  assign win_reached = (left_score == WIN) || (right_score == WIN);

  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:    if (start_evt) nxt = SERVE;
      SERVE:   nxt = PLAY;
      PLAY:    if (left_goal || right_goal) nxt = POINT;
      POINT:   if (cnt == 25'd0) nxt = win_reached ? OVER : SERVE;
      OVER:    if (start_evt) nxt = SERVE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur         <= IDLE;
      serve       <= 1'b0;
      play_en     <= 1'b0;
      game_over   <= 1'b0;
      winner      <= 1'b0;
      left_score  <= 4'd0;
      right_score <= 4'd0;
      cnt         <= 25'd0;
    end else begin
      cur       <= nxt;
      serve     <= (nxt == SERVE);
      play_en   <= (nxt == PLAY);
      game_over <= (nxt == OVER);
      // Left goal wins ties; the saturation guards keep a score from passing WIN.
      if (cur == PLAY && nxt == POINT) begin
        cnt <= DELAY_M1;
        if (left_goal) begin
          if (right_score < WIN) right_score <= right_score + 4'd1;
        end else if (left_score < WIN) begin
          left_score <= left_score + 4'd1;
        end
      end else if (cur == POINT && cnt != 25'd0) begin
        cnt <= cnt - 25'd1;
      end
      if (cur == POINT && nxt == OVER) winner <= (right_score == WIN);
      if (cur == OVER && nxt == SERVE) begin
        left_score  <= 4'd0;
        right_score <= 4'd0;
      end
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - directed table-driven bench for score_keeper (WIN_SCORE=2, SERVE_DELAY=4, DEBOUNCE_CYCLES=8).
module tb_score_keeper;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] ball_x_pos = 10'd320;
  logic       serve, play_en, game_over, winner;
  logic [3:0] left_score, right_score;
  logic [2:0] state;

  int checks = 0;
  int fails  = 0;

  score_keeper #(
    .WIN_SCORE(2), .LEFT_GOAL_X(10), .RIGHT_GOAL_X(630),
    .SERVE_DELAY(4), .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ball_x_pos(ball_x_pos),
    .serve(serve), .play_en(play_en), .left_score(left_score), .right_score(right_score),
    .game_over(game_over), .winner(winner), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic [9:0]  ball;
    int          waits;
    logic [14:0] exp;
  } vec_t;

  function automatic logic [14:0] pk(input logic [2:0] st, input logic sv, input logic pl,
                                     input logic [3:0] l, input logic [3:0] r,
                                     input logic go, input logic w);
    return {st, sv, pl, l, r, go, w};
  endfunction

  function automatic logic [14:0] outs();
    return {state, serve, play_en, left_score, right_score, game_over, winner};
  endfunction

  task automatic check(input string name, input logic [14:0] exp);
    checks++;
    if (outs() !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h (state,serve,play,left,right,over,winner)", name, outs(), exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  vec_t v[19];
  logic flag;
  int   serves;

  initial begin
    // inputs, edges to wait, expected outputs afterwards
    v[0]  = '{1'b1, 10'd320, 3, pk(3'd0, 0, 0, 4'd0, 4'd0, 0, 0)};
    v[1]  = '{1'b1, 10'd320, 1, pk(3'd1, 1, 0, 4'd0, 4'd0, 0, 0)};
    v[2]  = '{1'b1, 10'd320, 1, pk(3'd2, 0, 1, 4'd0, 4'd0, 0, 0)};
    v[3]  = '{1'b0, 10'd320, 5, pk(3'd2, 0, 1, 4'd0, 4'd0, 0, 0)};
    v[4]  = '{1'b0, 10'd5,   1, pk(3'd3, 0, 0, 4'd0, 4'd1, 0, 0)};
    v[5]  = '{1'b0, 10'd5,   3, pk(3'd3, 0, 0, 4'd0, 4'd1, 0, 0)};
    v[6]  = '{1'b0, 10'd320, 1, pk(3'd1, 1, 0, 4'd0, 4'd1, 0, 0)};
    v[7]  = '{1'b0, 10'd320, 1, pk(3'd2, 0, 1, 4'd0, 4'd1, 0, 0)};
    v[8]  = '{1'b0, 10'd635, 1, pk(3'd3, 0, 0, 4'd1, 4'd1, 0, 0)};
    v[9]  = '{1'b1, 10'd635, 3, pk(3'd3, 0, 0, 4'd1, 4'd1, 0, 0)};
    v[10] = '{1'b0, 10'd320, 1, pk(3'd1, 1, 0, 4'd1, 4'd1, 0, 0)};
    v[11] = '{1'b0, 10'd320, 1, pk(3'd2, 0, 1, 4'd1, 4'd1, 0, 0)};
    v[12] = '{1'b0, 10'd635, 1, pk(3'd3, 0, 0, 4'd2, 4'd1, 0, 0)};
    v[13] = '{1'b1, 10'd635, 3, pk(3'd3, 0, 0, 4'd2, 4'd1, 0, 0)};
    v[14] = '{1'b0, 10'd320, 1, pk(3'd4, 0, 0, 4'd2, 4'd1, 1, 0)};
    v[15] = '{1'b0, 10'd320, 5, pk(3'd4, 0, 0, 4'd2, 4'd1, 1, 0)};
    v[16] = '{1'b1, 10'd320, 3, pk(3'd4, 0, 0, 4'd2, 4'd1, 1, 0)};
    v[17] = '{1'b1, 10'd320, 1, pk(3'd1, 1, 0, 4'd0, 4'd0, 0, 0)};
    v[18] = '{1'b0, 10'd320, 1, pk(3'd2, 0, 1, 4'd0, 4'd0, 0, 0)};

    step(3);
    check("reset_state", pk(3'd0, 0, 0, 4'd0, 4'd0, 0, 0));
    reset_n = 1'b1;
    step(2);
    check("idle_after_release", pk(3'd0, 0, 0, 4'd0, 4'd0, 0, 0));

`ifndef SCORE_DEBOUNCE_EN
    for (int i = 0; i < 19; i++) begin
      start      = v[i].start;
      ball_x_pos = v[i].ball;
      step(v[i].waits);
      check($sformatf("vec%0d", i), v[i].exp);
    end

    // Score 1-0, then reset while in POINT.
    ball_x_pos = 10'd635;
    step(1);
    check("point_1_0", pk(3'd3, 0, 0, 4'd1, 4'd0, 0, 0));
    reset_n = 1'b0;
    #1;
    check("async_reset_in_point", pk(3'd0, 0, 0, 4'd0, 4'd0, 0, 0));
    step(3);
    ball_x_pos = 10'd320;
    reset_n = 1'b1;
    flag = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (serve !== 1'b0 || state !== 3'd0) flag = 1'b0;
    end
    checks++;
    if (!flag) begin
      fails++;
      $display("FAIL no_serve_after_reset: saw serve=%b state=%0d, want 0/0", serve, state);
    end

    // A fresh start after reset still begins a game.
    start = 1'b1;
    step(4);
    check("restart_serve", pk(3'd1, 1, 0, 4'd0, 4'd0, 0, 0));
    start = 1'b0;
`else
    // Debounced build: a short glitch is swallowed, a long pulse gives one serve.
    start = 1'b1;
    step(5);
    start = 1'b0;
    serves = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (serve === 1'b1) serves++;
    end
    checks++;
    if (serves != 0) begin
      fails++;
      $display("FAIL glitch_no_serve: got %0d serves want 0", serves);
    end
    check("glitch_still_idle", pk(3'd0, 0, 0, 4'd0, 4'd0, 0, 0));

    start = 1'b1;
    serves = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 12) start = 1'b0;
      step(1);
      if (serve === 1'b1) serves++;
    end
    checks++;
    if (serves != 1) begin
      fails++;
      $display("FAIL pulse_one_serve: got %0d serves want 1", serves);
    end
    check("pulse_in_play", pk(3'd2, 0, 1, 4'd0, 4'd0, 0, 0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 7: points that end a game, legal range 1..15.
REQ-002 SHALL have parameter LEFT_GOAL_X, default 10: ball_x_pos at or below this scores for the right player.
REQ-003 SHALL have parameter RIGHT_GOAL_X, default 630: ball_x_pos at or above this scores for the left player.
REQ-004 SHALL have parameter SERVE_DELAY, default 25000000: clk cycles spent in POINT, range 1..2^25-1.
REQ-005 SHALL have parameter DEBOUNCE_CYCLES, default 1000000: start stable time, range 1..2^20-1, used only with SCORE_DEBOUNCE_EN.
REQ-006 SHALL have port clk, input, 1 bit: rising-edge system clock.
REQ-007 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port start, input, 1 bit: asynchronous player button, active high.
REQ-009 SHALL have port ball_x_pos, input, 10 bits: ball horizontal position from the ball mover, unsigned.
REQ-010 SHALL have port serve, output, 1 bit: one-cycle pulse telling the ball mover to recentre.
REQ-011 SHALL have port play_en, output, 1 bit: high only in PLAY; ball movement permitted.
REQ-012 SHALL have ports left_score and right_score, output, 4 bits each: current points, unsigned.
REQ-013 SHALL have port game_over, output, 1 bit: high only in OVER.
REQ-014 SHALL have port winner, output, 1 bit: 0 means left won, 1 means right won; valid while game_over is high.
REQ-015 SHALL have port state, output, 3 bits: current FSM encoding, for debug.

Function
REQ-016 SHALL pass start through a 2-flop synchronizer, then a rising-edge detector producing a one-cycle start_evt.
REQ-017 SHALL implement FSM IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4; encodings 5..7 SHALL return to IDLE on the next clk.
REQ-018 IDLE: on start_evt, SHALL go to SERVE; all other inputs ignored.
REQ-019 SERVE: SHALL assert serve for exactly one cycle, then go to PLAY on the next clk.
REQ-020 PLAY: ball_x_pos <= LEFT_GOAL_X SHALL increment right_score and go to POINT in the same clk edge.
REQ-021 PLAY: otherwise, ball_x_pos >= RIGHT_GOAL_X SHALL increment left_score and go to POINT.
REQ-022 If both PLAY goal conditions hold, the left-goal case SHALL take priority; exactly one point SHALL be awarded per PLAY visit.
REQ-023 POINT: SHALL load a 25-bit counter with SERVE_DELAY-1 on entry and decrement it each cycle.
REQ-024 POINT: at count 0, SHALL go to OVER if either score equals WIN_SCORE, else to SERVE.
REQ-025 POINT: ball_x_pos SHALL be ignored, so a ball lingering past the goal never double-scores.
REQ-026 Entering OVER SHALL latch winner (1 if right_score == WIN_SCORE); scores SHALL hold.
REQ-027 OVER: on start_evt, SHALL clear both scores and go to SERVE.
REQ-028 Scores SHALL never exceed WIN_SCORE and never wrap.
REQ-029 All outputs SHALL be registered.
REQ-030 start_evt in SERVE, PLAY or POINT SHALL be discarded.

Reset
REQ-031 reset_n low SHALL asynchronously force: state=IDLE, both scores 0, serve 0, play_en 0, game_over 0, winner 0, counters 0, synchronizer flops 0.
REQ-032 Reset asserted mid-game, in any state, SHALL abandon the game; after release the block SHALL wait in IDLE for a new start_evt.

Configuration
REQ-033 Without SCORE_DEBOUNCE_EN, the synchronized start SHALL feed the edge detector directly; start_evt fires 3 clk edges after start goes high.
REQ-034 With SCORE_DEBOUNCE_EN, a 20-bit counter SHALL update a debounced level only after the synchronized start holds a new value for DEBOUNCE_CYCLES consecutive cycles; the edge detector SHALL use the debounced level.
REQ-035 With SCORE_DEBOUNCE_EN, glitches shorter than DEBOUNCE_CYCLES SHALL produce no start_evt.

Verification (SERVE_DELAY=4, DEBOUNCE_CYCLES=8 unless noted)
REQ-036 Reset, then pulse start high for 5 cycles -> serve high exactly 1 cycle, then play_en=1, state=2.
REQ-037 In PLAY, drive ball_x_pos=5 for 20 cycles -> right_score=1 once, play_en=0 for 4 POINT cycles, then serve pulse.
REQ-038 Set WIN_SCORE=2; force two ball_x_pos=635 points -> left_score=2, game_over=1, winner=0, further start glitches during POINT ignored.
REQ-039 In OVER, pulse start -> scores return to 0, serve pulses, play_en=1.
REQ-040 Assert reset_n low while in POINT with score 1-0 -> all outputs 0, state=0 immediately, no serve after release.
REQ-041 With SCORE_DEBOUNCE_EN defined, apply a 5-cycle start glitch -> no serve; apply a 12-cycle start pulse -> one serve.
